// File: rtl/maxpool2x2.sv
// maxpool2x2: 2x2, stride-2 max-pooling stage placed after the 5x5 conv stage.
// Walks the IDim x IDim input one window element per cycle and writes each
// ODim x ODim result element as its window completes.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset (aborts any pass, clears Out)
//   start  - level sampled in IDLE; starts one full pooling pass
//   In     - IDim x IDim feature map; must be held stable while busy=1
//   Out    - ODim x ODim pooled map, registered
//   busy   - high from the cycle after start is accepted through the done cycle
//   done   - one-cycle pulse; Out is fully valid from this cycle onward
module maxpool2x2 #(
  parameter int IDim       = 28,
  parameter int ODim       = IDim / 2,
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] In  [IDim][IDim],
  output logic [DATA_WIDTH-1:0] Out [ODim][ODim],
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (ODim > 1) ? $clog2(ODim) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           r, c;
  logic [1:0]              k;
  logic [DATA_WIDTH-1:0]   max_reg;
  logic [DATA_WIDTH-1:0]   elem;
  logic                    elem_gt;
  logic                    last_col;
  logic                    last_win;

  // Window element k: row 2r+k[1], column 2c+k[0]; concatenation gives 2x+bit.
  always_comb begin
    elem = In[{r, k[1]}][{c, k[0]}];
  end

  // Strictly greater: on a tie max_reg keeps its current value.
  assign elem_gt = SIGNED_CMP ? ($signed(elem) > $signed(max_reg))
                              : (elem > max_reg);

  assign last_col = (c == CW'(ODim - 1));
  assign last_win = last_col && (r == CW'(ODim - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CMP;
      end
      S_CMP: begin
        busy = 1'b1;
        if (k == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        state_nxt = last_win ? S_DONE : S_CMP;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Window counters, running maximum and result array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r       <= '0;
      c       <= '0;
      k       <= '0;
      max_reg <= '0;
      for (int unsigned i = 0; i < ODim; i++) begin
        for (int unsigned j = 0; j < ODim; j++) begin
          Out[i][j] <= '0;
        end
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            r <= '0;
            c <= '0;
            k <= '0;
          end
        end
        S_CMP: begin
          if (k == 2'd0 || elem_gt) max_reg <= elem;
          if (k != 2'd3) k <= k + 2'd1;
        end
        S_WRITE: begin
          Out[r][c] <= max_reg;
          k         <= '0;
          if (last_col) begin
            c <= '0;
            // Last window wraps r back to 0 so it never exceeds ODim-1.
            r <= last_win ? '0 : r + CW'(1);
          end else begin
            c <= c + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/maxpool2x2.md
Name: maxpool2x2

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the 5x5 convolution stage.
- Consumes the conv stage's 28x28 output array and produces a 14x14 array (LeNet C1→S2 path).
- Walks windows sequentially, one element per cycle, with a start/busy/done handshake so the next layer knows when the 14x14 result is valid.

Parameters:
IDim, 28, input array dimension (IDim x IDim); must be even
ODim, 14, output array dimension; fixed at IDim/2
DATA_WIDTH, 32, element width in bits
SIGNED_CMP, 1, 1 = elements compared as two's complement; 0 = unsigned

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  level sampled in IDLE; high starts one full pooling pass
In  input  DATA_WIDTH x [IDim][IDim]  feature map from conv stage; must be held stable while busy=1
Out  output  DATA_WIDTH x [ODim][ODim]  pooled map; registered
busy  output  1  high from cycle after start accepted until done cycle inclusive
done  output  1  one-cycle pulse; Out fully valid from this cycle onward

Behaviour:
- Reset (async, rst=1): state=IDLE; r=c=k=0; max_reg=0; every Out element=0; busy=0; done=0. Reset mid-pass aborts the pass immediately; no partial result is retained.
- Window (r,c), r,c in 0..ODim-1, covers In[2r][2c], In[2r][2c+1], In[2r+1][2c], In[2r+1][2c+1], read in that order (k=0..3).
- States:
  - IDLE: busy=0. On an edge with start=1: r=c=k=0, go to CMP.
  - CMP: k=0 loads max_reg with element 0. k=1..3 sets max_reg=max(max_reg, element k). Comparison is signed when SIGNED_CMP=1, unsigned otherwise; on equal values max_reg keeps its value. After k=3, go to WRITE.
  - WRITE: Out[r][c] <= max_reg; k=0. Advance c; at c=ODim-1 wrap c=0 and r++.
    - If (r,c) was (ODim-1,ODim-1): assert done=1 on the same edge and go to DONE.
    - Otherwise go to CMP.
  - DONE: busy=1, done=1 for this single cycle. Next edge: done=0, busy=0, go to IDLE.
- Timing, with edge 0 = IDLE sampling start=1:
  - busy rises after edge 0.
  - Window w (row-major, w=r*ODim+c) is written at edge 5(w+1).
  - Last write and done set occur at edge 5*ODim*ODim (980 for defaults). done clears and busy falls at edge 981.
- start is ignored in CMP/WRITE/DONE. If start is still high when IDLE is re-entered, a new pass begins on the next edge. A level-held start therefore re-runs continuously: done every 982 cycles.
- Out elements not yet rewritten in a pass hold their previous values. Out is guaranteed coherent only from the done cycle until the next start is accepted.
- No arithmetic growth: max_reg and Out are DATA_WIDTH wide, copied bit-exact from In.
- Counters r, c are ceil(log2(ODim)) bits; k is 2 bits. No counter ever exceeds ODim-1 or 3.

Test Plan:
- Ramp: In[i][j]=i*28+j, start pulse → done exactly once at cycle 981 after start sample; Out[r][c]=(2r+1)*28+2c+1 (Out[0][0]=29, Out[13][13]=783); busy high cycles 1..981.
- Position coverage: all zeros except one 5 per window, the 5 placed at k=(r+c)%4 → every Out element = 5; proves each window slot is compared.
- Signed compare: window {0xFFFFFFFF, 0x00000003, 0x80000000, 0x00000000}, SIGNED_CMP=1 → 0x00000003; same data with SIGNED_CMP=0 → 0xFFFFFFFF.
- Reset mid-pass: assert rst at cycle 400 → Out all 0, busy=0, done=0 immediately; rerun pass completes with the ramp result and done at +981.
- Start while busy: pulse start at cycles 0 and 300 → single done at 981, no restart. Start held high from cycle 0 → done at cycles 981 and 1963.
- Ties: window of all 0x7FFFFFFF, plus an all-equal negative window 0x80000000 (signed) → outputs equal those values exactly.
